operand_entry_controller: RTL and testbench

Upstream stage of the sequential multiplier display path. It takes mechanical push-buttons and one shared WIDTH-bit switch bank, synchronises and debounces the buttons, and captures the multiplicand and then the multiplier in two button presses. It then issues a one-cycle active-low start request to the multiplier/display stage and waits for that stage's ready to complete a full handshake. Outputs drive the downstream multiplicand, multiplier and start_n inputs directly.

---
 rtl/operand_entry_pkg.sv | 22 ++
 rtl/button_debouncer.sv | 47 ++++
 rtl/operand_entry_controller.sv | 95 +++++++++
 tb/tb_operand_entry_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared FSM states, LED phase codes and sizing helper
package operand_entry_pkg;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        START     = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4,
        DONE      = 3'd5
    } entry_state_t;

    localparam logic [1:0] PHASE_A    = 2'd0;
    localparam logic [1:0] PHASE_B    = 2'd1;
    localparam logic [1:0] PHASE_CALC = 2'd2;
    localparam logic [1:0] PHASE_DONE = 2'd3;

    function automatic int get_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop sync, stability counter and press pulse for an active-low button
module button_debouncer
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = get_cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          synced, flip;

    assign synced = sync_q[1];
    // the level flips on the cycle the disagreement has lasted DEBOUNCE_CYCLES cycles
    assign flip   = (synced != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d   = (synced == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? synced : level_q;
        press_d = flip & ~synced;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/operand_entry_controller.sv
// operand_entry_controller: button-driven two-operand capture and start/ready handshake
// for the sequential multiplier display path
module operand_entry_controller
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHECK_PARAM     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] switches,
    input  logic             ready,
    output logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH-1:0] multiplier,
    output logic             start_n,
    output logic             busy,
    output logic [1:0]       phase
);

    if (CHECK_PARAM != 0 && (WIDTH == 0 || DEBOUNCE_CYCLES < 2)) begin : g_chk
        $fatal(1, "operand_entry_controller: WIDTH must be >0 and DEBOUNCE_CYCLES >= 2");
    end

    entry_state_t     state_q, state_d;
    logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
    logic             key_press, clear_press, key_go;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (key_n),
        .press_o (key_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (clear_n),
        .press_o (clear_press)
    );

    // clear has priority: a coincident key press must not capture an operand
    assign key_go = key_press & ~clear_press;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            LOAD_A: if (key_go) begin
                mcand_d = sw_sync_q;
                state_d = LOAD_B;
            end
            LOAD_B: if (key_go) begin
                mplier_d = sw_sync_q;
                state_d  = START;
            end
            START:     state_d = WAIT_LOW;
            WAIT_LOW:  state_d = ready ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: state_d = ready ? DONE : WAIT_HIGH;
            DONE:      state_d = key_go ? LOAD_A : DONE;
            default:   state_d = LOAD_A;
        endcase
        if (clear_press) state_d = LOAD_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD_A;
            sw_meta_q <= '1;
            sw_sync_q <= '1;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            state_q   <= state_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    assign multiplicand = mcand_q;
    assign multiplier   = mplier_q;
    assign start_n      = (state_q != START);
    assign busy         = (state_q == START) || (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
    assign phase        = (state_q == LOAD_B) ? PHASE_B :
                          (state_q == DONE)   ? PHASE_DONE :
                          busy                ? PHASE_CALC : PHASE_A;

endmodule

// File: tb/tb_operand_entry_controller.sv
// tb_operand_entry_controller: directed checks of capture, debounce, handshake, clear and reset
module tb_operand_entry_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       clear_n = 1'b1;
    logic [7:0] switches = 8'h00;
    logic       ready = 1'b1;
    logic [7:0] multiplicand, multiplier;
    logic       start_n, busy;
    logic [1:0] phase;
    int         n_cmp = 0;
    int         n_err = 0;
    int         start_cnt = 0;

    operand_entry_controller #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CHECK_PARAM(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_n        (key_n),
        .clear_n      (clear_n),
        .switches     (switches),
        .ready        (ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .start_n      (start_n),
        .busy         (busy),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && !start_n) start_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key();
        key_n = 1'b0;
        tick(10);
        key_n = 1'b1;
        tick(10);
    endtask

    initial begin
        #2;
        check("rst_mcand", multiplicand, 8'h00);
        check("rst_mplier", multiplier, 8'h00);
        check("rst_start_n", start_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_phase", phase, 2'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        // scenario 1: full entry and handshake
        switches = 8'h07;
        press_key();
        check("s1_mcand", multiplicand, 8'h07);
        check("s1_phase_b", phase, 2'd1);
        switches = 8'hFD;
        key_n = 1'b0;
        tick(6);
        check("s1_latency_phase", phase, 2'd1);
        tick(1);
        check("s1_mplier", multiplier, 8'hFD);
        check("s1_start_low", start_n, 1'b0);
        check("s1_busy_start", busy, 1'b1);
        tick(1);
        check("s1_start_high", start_n, 1'b1);
        // scenario 4: held key and early ready high leave WAIT_LOW untouched
        tick(10);
        check("s4_no_early_done", phase, 2'd2);
        check("s4_busy", busy, 1'b1);
        key_n = 1'b1;
        tick(8);
        ready = 1'b0;
        tick(1);
        check("s1_wait_high", busy, 1'b1);
        ready = 1'b1;
        tick(1);
        check("s1_done_phase", phase, 2'd3);
        check("s1_done_busy", busy, 1'b0);
        check("s1_start_count", start_cnt, 1);
        // scenario 2: glitch rejected, 6-cycle low accepted
        press_key();
        check("s2_back_to_a", phase, 2'd0);
        switches = 8'h5A;
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(10);
        check("s2_glitch_phase", phase, 2'd0);
        check("s2_glitch_mcand", multiplicand, 8'h07);
        key_n = 1'b0;
        tick(6);
        check("s2_pre_phase", phase, 2'd0);
        tick(1);
        check("s2_post_phase", phase, 2'd1);
        check("s2_mcand", multiplicand, 8'h5A);
        key_n = 1'b1;
        tick(10);
        // clear from LOAD_B keeps operands
        clear_n = 1'b0;
        tick(10);
        clear_n = 1'b1;
        tick(10);
        check("clr_phase", phase, 2'd0);
        check("clr_mcand", multiplicand, 8'h5A);
        check("clr_mplier", multiplier, 8'hFD);
        // scenario 3: long hold captures only A
        switches = 8'h33;
        key_n = 1'b0;
        tick(10);
        switches = 8'hC4;
        tick(40);
        check("s3_phase", phase, 2'd1);
        check("s3_mcand", multiplicand, 8'h33);
        check("s3_mplier", multiplier, 8'hFD);
        key_n = 1'b1;
        tick(10);
        // scenario 5: simultaneous clear and key in LOAD_B
        switches = 8'h99;
        key_n = 1'b0;
        clear_n = 1'b0;
        tick(10);
        check("s5_phase", phase, 2'd0);
        check("s5_mplier", multiplier, 8'hFD);
        check("s5_start_count", start_cnt, 1);
        key_n = 1'b1;
        clear_n = 1'b1;
        tick(10);
        // scenario 6: ignored presses while busy, then async reset in WAIT_HIGH
        switches = 8'h12;
        press_key();
        switches = 8'h34;
        press_key();
        check("s6_mplier", multiplier, 8'h34);
        press_key();
        check("s6_wait_low_ignore", phase, 2'd2);
        ready = 1'b0;
        tick(1);
        press_key();
        check("s6_wait_high_ignore", busy, 1'b1);
        check("s6_start_count", start_cnt, 2);
        rst_n = 1'b0;
        #2;
        check("s6_async_phase", phase, 2'd0);
        check("s6_async_busy", busy, 1'b0);
        check("s6_async_mcand", multiplicand, 8'h00);
        check("s6_async_mplier", multiplier, 8'h00);
        check("s6_async_start_n", start_n, 1'b1);
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(3);
        switches = 8'h81;
        press_key();
        switches = 8'h7F;
        press_key();
        check("s6_re_mcand", multiplicand, 8'h81);
        check("s6_re_mplier", multiplier, 8'h7F);
        check("s6_re_start_count", start_cnt, 3);
        ready = 1'b0;
        tick(1);
        ready = 1'b1;
        tick(1);
        check("s6_re_done", phase, 2'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
